// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the softcore memory bridge.
package rv_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLo,
    StHi,
    StBs,
    StDone
  } state_e;

  // addr[22:20] value that selects on-chip BSRAM
  localparam logic [2:0] BSRAM_REGION = 3'b111;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  function automatic logic [21:0] half_addr(input logic [20:0] word, input logic half);
    return {word, half};
  endfunction

endpackage

// File: rtl/rv_bsram.sv
// Single-port 32-bit RAM with byte enables and registered read, BSRAM-inferable.
module rv_bsram #(
  parameter int unsigned BSRAM_AW = 11
) (
  input  logic                clk,
  input  logic                en,
  input  logic [3:0]          we,
  input  logic [BSRAM_AW-1:0] addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata
);

  logic [31:0] mem [2**BSRAM_AW];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/rv_mem_bridge.sv
// Softcore memory responder: SDRAM as two half-word accesses, top 1 MB to BSRAM.
// Define RV_BRIDGE_READ_CACHE_EN to add a single-entry SDRAM read cache.
module rv_mem_bridge
  import rv_mem_pkg::*;
#(
  parameter int unsigned BSRAM_AW        = 11,
  parameter bit          SKIP_EMPTY_HALF = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rv_valid,
  output logic        rv_ready,
  input  logic [22:0] rv_addr,
  input  logic [31:0] rv_wdata,
  input  logic [3:0]  rv_wstrb,
  output logic [31:0] rv_rdata,
  output logic        sd_req,
  output logic [21:0] sd_addr,
  output logic        sd_we,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_be,
  input  logic [15:0] sd_dout,
  input  logic        sd_ack
);

  state_e      state;
  logic [20:0] word;
  logic [31:0] wdata_l;
  logic [3:0]  wstrb_l;
  logic [15:0] lo_data;
  logic        via_bs;

  logic        req_bs, req_wr, skip_lo, skip_hi, hit_now;
  logic [31:0] ram_q, bs_rdata;
  logic        ram_en;
  logic [BSRAM_AW-1:0] ram_addr;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^rv_addr[1:0];

  assign req_bs  = rv_addr[22:20] == BSRAM_REGION;
  assign req_wr  = |rv_wstrb;
  assign skip_lo = SKIP_EMPTY_HALF && req_wr && (rv_wstrb[1:0] == 2'b00);
  assign skip_hi = SKIP_EMPTY_HALF && (|wstrb_l) && (wstrb_l[3:2] == 2'b00);

  // Reads are issued at the capture edge so the data is ready when leaving StBs.
  assign ram_addr = (state == StIdle) ? rv_addr[BSRAM_AW+1:2] : word[BSRAM_AW-1:0];
  assign ram_en   = ((state == StIdle) && rv_valid && req_bs) || ((state == StBs) && |wstrb_l);

  rv_bsram #(
    .BSRAM_AW (BSRAM_AW)
  ) u_bsram (
    .clk   (clk),
    .en    (ram_en),
    .we    ((state == StBs) ? wstrb_l : 4'b0000),
    .addr  (ram_addr),
    .wdata (wdata_l),
    .rdata (ram_q)
  );

`ifdef RV_BRIDGE_READ_CACHE_EN
  logic        cache_valid, hit;
  logic [20:0] cache_tag;
  logic [31:0] cache_data;

  assign hit_now  = cache_valid && (cache_tag == rv_addr[22:2]) && !req_wr && !req_bs;
  assign bs_rdata = hit ? cache_data : ram_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cache_valid <= 1'b0;
      hit         <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
    end else begin
      if ((state == StIdle) && rv_valid) begin
        hit <= hit_now;
        // Keep the entry coherent with SDRAM writes to the tagged word
        if (!req_bs && req_wr && cache_valid && (cache_tag == rv_addr[22:2])) begin
          for (int b = 0; b < 4; b++) begin
            if (rv_wstrb[b]) cache_data[8*b +: 8] <= rv_wdata[8*b +: 8];
          end
        end
      end
      if ((state == StDone) && !via_bs && (wstrb_l == 4'b0000)) begin
        cache_valid <= 1'b1;
        cache_tag   <= word;
        cache_data  <= rv_rdata;
      end
    end
  end
`else
  assign hit_now  = 1'b0;
  assign bs_rdata = ram_q;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= StIdle;
      rv_ready <= 1'b0;
      rv_rdata <= '0;
      sd_req   <= 1'b0;
      sd_we    <= 1'b0;
      sd_be    <= '0;
      sd_addr  <= '0;
      sd_din   <= '0;
      word     <= '0;
      wdata_l  <= '0;
      wstrb_l  <= '0;
      lo_data  <= '0;
      via_bs   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (rv_valid) begin
            word    <= rv_addr[22:2];
            wdata_l <= rv_wdata;
            wstrb_l <= rv_wstrb;
            via_bs  <= req_bs || hit_now;
            if (req_bs || hit_now) begin
              state <= StBs;
            end else begin
              sd_req <= 1'b1;
              sd_we  <= req_wr;
              if (skip_lo) begin
                state   <= StHi;
                sd_addr <= half_addr(rv_addr[22:2], HALF_HI);
                sd_din  <= rv_wdata[31:16];
                sd_be   <= rv_wstrb[3:2];
              end else begin
                state   <= StLo;
                sd_addr <= half_addr(rv_addr[22:2], HALF_LO);
                sd_din  <= rv_wdata[15:0];
                sd_be   <= req_wr ? rv_wstrb[1:0] : 2'b11;
              end
            end
          end
        end
        StLo: begin
          if (sd_ack) begin
            sd_req  <= 1'b0;
            lo_data <= sd_dout;
            if (skip_hi) begin
              state    <= StDone;
              rv_ready <= 1'b1;
              rv_rdata <= '0;
            end else begin
              state   <= StHi;
              sd_addr <= half_addr(word, HALF_HI);
              sd_din  <= wdata_l[31:16];
              sd_be   <= (|wstrb_l) ? wstrb_l[3:2] : 2'b11;
            end
          end
        end
        StHi: begin
          // sd_req is low for one cycle after the low-half ack before re-asserting
          if (!sd_req) begin
            sd_req <= 1'b1;
          end else if (sd_ack) begin
            sd_req   <= 1'b0;
            state    <= StDone;
            rv_ready <= 1'b1;
            rv_rdata <= (|wstrb_l) ? 32'h0 : {sd_dout, lo_data};
          end
        end
        StBs: begin
          state    <= StDone;
          rv_ready <= 1'b1;
          rv_rdata <= (|wstrb_l) ? 32'h0 : bs_rdata;
        end
        StDone: begin
          state    <= StIdle;
          rv_ready <= 1'b0;
          rv_rdata <= '0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_bridge.sv
// Directed bench for rv_mem_bridge with a transaction-level memory model and SDRAM responder.
module tb_rv_mem_bridge;

  typedef struct packed {
    logic [21:0] addr;
    logic        we;
    logic [15:0] din;
    logic [1:0]  be;
  } sd_rec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rv_valid, rv_ready;
  logic [22:0] rv_addr;
  logic [31:0] rv_wdata, rv_rdata;
  logic [3:0]  rv_wstrb;
  logic        sd_req, sd_we, sd_ack;
  logic [21:0] sd_addr;
  logic [15:0] sd_din, sd_dout;
  logic [1:0]  sd_be;

  int n_cmp = 0;
  int n_bad = 0;
  int ready_cnt = 0;
  int ack_delay = 0;
  bit stray_ack = 1'b0;
  logic [31:0] last_rsp = '0;

  sd_rec_t exp_sd[$];
  sd_rec_t sd_seen[$];
  sd_rec_t hist[$];
  logic [31:0] exp_rsp[$];

  logic [31:0] sd_ref [logic [20:0]];
  logic [31:0] bs_ref [int];
  logic [15:0] sd_mem [logic [21:0]];

  rv_mem_bridge dut (
    .clk      (clk),
    .resetn   (resetn),
    .rv_valid (rv_valid),
    .rv_ready (rv_ready),
    .rv_addr  (rv_addr),
    .rv_wdata (rv_wdata),
    .rv_wstrb (rv_wstrb),
    .rv_rdata (rv_rdata),
    .sd_req   (sd_req),
    .sd_addr  (sd_addr),
    .sd_we    (sd_we),
    .sd_din   (sd_din),
    .sd_be    (sd_be),
    .sd_dout  (sd_dout),
    .sd_ack   (sd_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Model: what a request must do, from the address map and strobe rules.
  task automatic model_push(input logic [22:0] a, input logic [31:0] d, input logic [3:0] s);
    int          k;
    logic [20:0] w;
    logic [31:0] cur;
    if (a[22:20] == 3'b111) begin
      k   = int'(a[12:2]);
      cur = bs_ref.exists(k) ? bs_ref[k] : 32'h0;
      if (s == 4'h0) exp_rsp.push_back(cur);
      else begin
        bs_ref[k] = merge(cur, d, s);
        exp_rsp.push_back(32'h0);
      end
    end else begin
      w   = a[22:2];
      cur = sd_ref.exists(w) ? sd_ref[w] : 32'h0;
      if (s == 4'h0) begin
        exp_sd.push_back('{addr: {w, 1'b0}, we: 1'b0, din: 16'h0, be: 2'b11});
        exp_sd.push_back('{addr: {w, 1'b1}, we: 1'b0, din: 16'h0, be: 2'b11});
        exp_rsp.push_back(cur);
      end else begin
        if (s[1:0] != 2'b00) exp_sd.push_back('{addr: {w, 1'b0}, we: 1'b1, din: d[15:0], be: s[1:0]});
        if (s[3:2] != 2'b00) exp_sd.push_back('{addr: {w, 1'b1}, we: 1'b1, din: d[31:16], be: s[3:2]});
        sd_ref[w] = merge(cur, d, s);
        exp_rsp.push_back(32'h0);
      end
    end
  endtask

  // SDRAM responder: acks after ack_delay cycles of sd_req, backed by a half-word memory.
  initial begin
    int wait_cnt = 0;
    sd_ack  = 1'b0;
    sd_dout = '0;
    forever begin
      @(negedge clk);
      if (sd_ack) begin
        sd_ack   = 1'b0;
        wait_cnt = 0;
      end else if (stray_ack) begin
        sd_ack    = 1'b1;
        stray_ack = 1'b0;
      end else if (sd_req && resetn) begin
        if (wait_cnt >= ack_delay) begin
          sd_ack = 1'b1;
          sd_seen.push_back('{addr: sd_addr, we: sd_we, din: sd_din, be: sd_be});
          sd_dout = sd_mem.exists(sd_addr) ? sd_mem[sd_addr] : 16'h0;
          if (sd_we) begin
            if (sd_be[0]) sd_mem[sd_addr][7:0] = sd_din[7:0];
            if (sd_be[1]) sd_mem[sd_addr][15:8] = sd_din[15:8];
            if (!sd_mem.exists(sd_addr)) sd_mem[sd_addr] = 16'h0;
          end
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  // Compare process: checks accesses, responses and idle-bus rules every cycle.
  initial begin
    sd_rec_t r, e;
    forever begin
      @(posedge clk);
      #1;
      while (sd_seen.size() > 0) begin
        r = sd_seen.pop_front();
        hist.push_back(r);
        check("sd access was expected", 32'(exp_sd.size() > 0), 32'd1);
        if (exp_sd.size() > 0) begin
          e = exp_sd.pop_front();
          check("sd_addr", 32'(r.addr), 32'(e.addr));
          check("sd_we", 32'(r.we), 32'(e.we));
          check("sd_be", 32'(r.be), 32'(e.be));
          if (e.we) check("sd_din", 32'(r.din), 32'(e.din));
        end
        check("sd_req low after ack", 32'(sd_req), 32'd0);
      end
      if (exp_sd.size() == 0) check("sd_req idle", 32'(sd_req), 32'd0);
      if (rv_ready) begin
        ready_cnt++;
        last_rsp = rv_rdata;
        check("rv_ready was expected", 32'(exp_rsp.size() > 0), 32'd1);
        if (exp_rsp.size() > 0) check("rv_rdata", rv_rdata, exp_rsp.pop_front());
      end
    end
  end

  task automatic rv_xfer(input logic [22:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit pulse, output int lat);
    model_push(a, d, s);
    @(negedge clk);
    rv_valid = 1'b1;
    rv_addr  = a;
    rv_wdata = d;
    rv_wstrb = s;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (pulse && k == 1) rv_valid = 1'b0;
      if (rv_ready) begin
        lat = k;
        break;
      end
    end
    rv_valid = 1'b0;
    check("rv_ready within bound", 32'(lat != 0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, h, r0;
    resetn = 1'b0; rv_valid = 1'b0; rv_addr = '0; rv_wdata = '0; rv_wstrb = '0;
    repeat (3) @(negedge clk);
    check("reset rv_ready", 32'(rv_ready), 32'd0);
    check("reset rv_rdata", rv_rdata, 32'd0);
    check("reset sd_req", 32'(sd_req), 32'd0);
    check("reset sd_we", 32'(sd_we), 32'd0);
    check("reset sd_be", 32'(sd_be), 32'd0);
    check("reset sd_addr", 32'(sd_addr), 32'd0);
    check("reset sd_din", 32'(sd_din), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Full-word SDRAM write then read back
    ack_delay = 1; h = hist.size(); r0 = ready_cnt;
    rv_xfer(23'h001000, 32'hDEADBEEF, 4'hF, 1'b0, lat);
    check("wr access count", 32'(hist.size() - h), 32'd2);
    check("wr lo addr", 32'(hist[h].addr), 32'h000800);
    check("wr lo be", 32'(hist[h].be), 32'h3);
    check("wr lo din", 32'(hist[h].din), 32'hBEEF);
    check("wr hi addr", 32'(hist[h+1].addr), 32'h000801);
    check("wr hi din", 32'(hist[h+1].din), 32'hDEAD);
    check("wr ready count", 32'(ready_cnt - r0), 32'd1);
    ack_delay = 0;
    rv_xfer(23'h001000, 32'h0, 4'h0, 1'b0, lat);
    check("rd literal", last_rsp, 32'hDEADBEEF);

    // Single upper byte write: only the high half goes out
    ack_delay = 2; h = hist.size();
    rv_xfer(23'h002000, 32'h00AB0000, 4'b0100, 1'b0, lat);
    check("hi-only access count", 32'(hist.size() - h), 32'd1);
    check("hi-only addr", 32'(hist[h].addr), 32'h001001);
    check("hi-only be", 32'(hist[h].be), 32'h1);
    check("hi-only din", 32'(hist[h].din), 32'h00AB);

    // Low-half-only write
    h = hist.size();
    rv_xfer(23'h003000, 32'h11223344, 4'b0011, 1'b0, lat);
    check("lo-only access count", 32'(hist.size() - h), 32'd1);
    check("lo-only addr", 32'(hist[h].addr), 32'h001800);
    ack_delay = 3;
    rv_xfer(23'h003000, 32'h0, 4'h0, 1'b0, lat);
    check("lo-only readback", last_rsp, 32'h00003344);

    // BSRAM: two-cycle latency, no SDRAM traffic, aliasing above BSRAM_AW
    h = hist.size();
    rv_xfer(23'h700004, 32'h12345678, 4'hF, 1'b0, lat);
    check("bs wr latency", 32'(lat), 32'd2);
    rv_xfer(23'h700004, 32'h0, 4'h0, 1'b0, lat);
    check("bs rd latency", 32'(lat), 32'd2);
    check("bs rd literal", last_rsp, 32'h12345678);
    rv_xfer(23'h702004, 32'hCAFEF00D, 4'b0011, 1'b1, lat);
    rv_xfer(23'h700004, 32'h0, 4'h0, 1'b0, lat);
    check("bs alias literal", last_rsp, 32'h1234F00D);
    check("bs no sdram", 32'(hist.size() - h), 32'd0);

    // Flash-loader style single-cycle pulses, 40 cycles apart
    ack_delay = 1; h = hist.size(); r0 = ready_cnt;
    rv_xfer(23'h000100, 32'h000000A5, 4'b0001, 1'b1, lat);
    repeat (37) @(negedge clk);
    rv_xfer(23'h000100, 32'h00005A00, 4'b0010, 1'b1, lat);
    repeat (10) @(negedge clk);
    check("pulse ready count", 32'(ready_cnt - r0), 32'd2);
    check("pulse access count", 32'(hist.size() - h), 32'd2);
    check("pulse 1 addr", 32'(hist[h].addr), 32'h000080);
    check("pulse 2 be", 32'(hist[h+1].be), 32'h2);
    rv_xfer(23'h000100, 32'h0, 4'h0, 1'b1, lat);
    check("pulse readback", last_rsp, 32'h00005AA5);

    // Reset while the high half waits for its ack; a late ack must be ignored
    ack_delay = 6; h = hist.size(); r0 = ready_cnt;
    model_push(23'h001000, 32'h0, 4'h0);
    @(negedge clk);
    rv_valid = 1'b1; rv_addr = 23'h001000; rv_wstrb = 4'h0;
    @(negedge clk);
    rv_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (hist.size() == h + 1 && sd_req) begin
        lat = 1;
        break;
      end
    end
    check("reached high half", 32'(lat), 32'd1);
    resetn = 1'b0;
    exp_sd.delete();
    exp_rsp.delete();
    @(negedge clk);
    check("reset drops sd_req", 32'(sd_req), 32'd0);
    check("reset no rv_ready", 32'(rv_ready), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    stray_ack = 1'b1;
    repeat (10) @(negedge clk);
    check("stray ack no ready", 32'(ready_cnt - r0), 32'd0);
    check("stray ack no access", 32'(hist.size() - h), 32'd1);

    ack_delay = 1;
    rv_xfer(23'h001000, 32'h0, 4'h0, 1'b0, lat);
    check("post-reset readback", last_rsp, 32'hDEADBEEF);

    repeat (5) @(negedge clk);
    check("sd queue drained", 32'(exp_sd.size()), 32'd0);
    check("rsp queue drained", 32'(exp_rsp.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
